// File: rtl/muldiv_seq.sv
// Sequential HI/LO multiply/divide unit with pipeline interlock.
// Ports: clk, rst_n, valid/opcode/funct/rs_val/rt_val/flush in; stall, busy, result, result_valid, hi, lo, div_by_zero out.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam logic [5:0] RTYPE   = 6'h00;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] m;
  logic [2*WIDTH-1:0] acc;
  logic             neg_q;
  logic             neg_r;
  logic             is_div;
  logic             dz;

  logic is_mf, is_mt, is_md, hiop, accept;
  logic sgn, rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag;

  assign is_mf  = (funct == F_MFHI) | (funct == F_MFLO);
  assign is_mt  = (funct == F_MTHI) | (funct == F_MTLO);
  assign is_md  = (funct == F_MULT) | (funct == F_MULTU)
                | (funct == F_DIV)  | (funct == F_DIVU);
  assign hiop   = valid & (opcode == RTYPE) & (is_mf | is_mt | is_md);
  assign busy   = (state != IDLE);
  assign stall  = hiop & busy;
  assign accept = hiop & ~busy & ~flush;

  assign result_valid = hiop & is_mf & ~stall;
  assign result = !result_valid ? '0 :
                  (funct == F_MFLO) ? lo : hi;

  // funct[0] clear marks the signed variants
  assign sgn    = ~funct[0];
  assign rs_neg = sgn & rs_val[WIDTH-1];
  assign rt_neg = sgn & rt_val[WIDTH-1];
  assign rs_mag = rs_neg ? -rs_val : rs_val;
  assign rt_mag = rt_neg ? -rt_val : rt_val;

  // shift-add: acc = {partial product, remaining multiplier bits}
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
                  + (acc[0] ? {1'b0, m} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // restoring divide: acc = {remainder, dividend/quotient}
  // remainder < divisor keeps the trial difference within WIDTH+1 bits
  logic [WIDTH:0]       div_sh, div_diff;
  logic [WIDTH-1:0]     div_rem;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   div_next;
  assign div_sh   = acc[2*WIDTH-1:WIDTH-1];
  assign div_diff = div_sh - {1'b0, m};
  assign div_ge   = ~div_diff[WIDTH];
  assign div_rem  = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
  assign div_next = {div_rem, acc[WIDTH-2:0], div_ge};

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;
  assign prod = neg_q ? -acc : acc;
  assign quo  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      hi          <= '0;
      lo          <= '0;
      m           <= '0;
      acc         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      is_div      <= 1'b0;
      dz          <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      div_by_zero <= 1'b0;
      if (flush) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (accept && funct == F_MTHI) hi <= rs_val;
            if (accept && funct == F_MTLO) lo <= rs_val;
            if (accept && is_md) begin
              cnt    <= '0;
              is_div <= funct[1];
              neg_q  <= rs_neg ^ rt_neg;
              neg_r  <= rs_neg;
              if (funct[1]) begin
                // zero divisor keeps the raw dividend so it lands in HI
                dz    <= (rt_val == '0);
                m     <= rt_mag;
                acc   <= {{WIDTH{1'b0}},
                          (rt_val == '0) ? rs_val : rs_mag};
                state <= DIV;
              end else begin
                dz    <= 1'b0;
                m     <= rs_mag;
                acc   <= {{WIDTH{1'b0}}, rt_mag};
                state <= MUL;
              end
            end
          end
          MUL, DIV: begin
            acc <= (state == MUL) ? mul_next : div_next;
            if (cnt == CW'(WIDTH - 1)) begin
              state       <= DONE;
              div_by_zero <= is_div & dz;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
            cnt   <= '0;
            if (!is_div) begin
              hi <= prod[2*WIDTH-1:WIDTH];
              lo <= prod[WIDTH-1:0];
            end else if (dz) begin
              hi <= acc[2*WIDTH-1:WIDTH];
              lo <= '1;
            end else begin
              hi <= rem;
              lo <= quo;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed, boundary and random ops.
// Expected HI/LO, busy length and div_by_zero pulses are queued per op.
module tb_muldiv_seq;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        valid = 0;
  logic [5:0]  opcode = 0;
  logic [5:0]  funct = 0;
  logic [31:0] rs_val = 0;
  logic [31:0] rt_val = 0;
  logic        flush = 0;
  logic        stall, busy, result_valid, div_by_zero;
  logic [31:0] result, hi, lo;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .opcode(opcode),
    .funct(funct), .rs_val(rs_val), .rt_val(rt_val), .flush(flush),
    .stall(stall), .busy(busy), .result(result),
    .result_valid(result_valid), .hi(hi), .lo(lo),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
    int          dz;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  logic [31:0] m_hi = 0;
  logic [31:0] m_lo = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard monitor: an op ends when busy falls
  bit prev_busy = 0;
  int busy_cnt = 0;
  int dz_cnt = 0;
  always @(negedge clk) begin
    exp_t e;
    if (busy) begin
      busy_cnt++;
      if (div_by_zero) dz_cnt++;
    end
    if (prev_busy && !busy) begin
      if (sb.size() == 0) begin
        chk("sb_empty_pop", 1, 0);
      end else begin
        e = sb.pop_front();
        chk({e.tag, "_hi"}, hi, e.hi);
        chk({e.tag, "_lo"}, lo, e.lo);
        chk({e.tag, "_dz"}, dz_cnt, e.dz);
        if (e.cyc >= 0) chk({e.tag, "_busy"}, busy_cnt, e.cyc);
      end
      busy_cnt = 0;
      dz_cnt = 0;
    end
    prev_busy = busy;
  end

  function automatic void model(input logic [5:0] f,
                                input logic [31:0] a, b,
                                output logic [31:0] h, l,
                                output int z);
    longint sa, sb_, ua, ub, p, q, r;
    sa = longint'($signed(a));
    sb_ = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    z = 0;
    p = 0; q = 0; r = 0;
    if (f == F_MULT) p = sa * sb_;
    else if (f == F_MULTU) p = ua * ub;
    if (f == F_MULT || f == F_MULTU) begin
      h = p[63:32];
      l = p[31:0];
    end else if (b == 0) begin
      h = a;
      l = '1;
      z = 1;
    end else begin
      if (f == F_DIV) begin
        q = sa / sb_;
        r = sa % sb_;
      end else begin
        q = ua / ub;
        r = ua % ub;
      end
      h = r[31:0];
      l = q[31:0];
    end
  endfunction

  task automatic present(input logic [5:0] f, input logic [31:0] a, b);
    valid = 1;
    opcode = 6'h00;
    funct = f;
    rs_val = a;
    rt_val = b;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk({tag, "_timeout"}, 1, 0);
    @(posedge clk);
  endtask

  // run one MULT/DIV and queue its expected outcome
  task automatic md_op(input string tag, input logic [5:0] f,
                       input logic [31:0] a, b);
    exp_t e;
    int z;
    model(f, a, b, e.hi, e.lo, z);
    e.tag = tag;
    e.dz = z;
    e.cyc = 33;
    @(posedge clk); #1;
    present(f, a, b);
    sb.push_back(e);
    @(posedge clk); #1;
    valid = 0;
    wait_idle(tag);
    m_hi = e.hi;
    m_lo = e.lo;
  endtask

  task automatic mt_op(input logic [5:0] f, input logic [31:0] a);
    @(posedge clk); #1;
    present(f, a, 0);
    @(posedge clk); #1;
    valid = 0;
    if (f == F_MTHI) m_hi = a;
    else m_lo = a;
  endtask

  task automatic mf_chk(input string tag, input logic [5:0] f,
                        input logic [31:0] exp);
    @(posedge clk); #1;
    present(f, 0, 0);
    @(negedge clk);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_rv"}, result_valid, 1);
    chk({tag, "_res"}, result, exp);
    @(posedge clk); #1;
    valid = 0;
  endtask

  initial begin
    exp_t e;
    int n;
    logic [5:0] fr;
    logic [31:0] ra, rb;

    #12;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dz", div_by_zero, 0);
    rst_n = 1;

    md_op("mult", F_MULT, 32'hFFFFFFFE, 3);
    chk("mult_hi_k", m_hi, 32'hFFFFFFFF);
    md_op("multu", F_MULTU, 32'hFFFFFFFE, 3);
    chk("multu_hi_k", m_hi, 32'h00000002);
    md_op("div", F_DIV, 32'hFFFFFFF9, 2);
    chk("div_lo_k", m_lo, 32'hFFFFFFFD);
    md_op("divu", F_DIVU, 7, 2);
    md_op("div_min", F_DIV, 32'h80000000, 32'hFFFFFFFF);
    chk("div_min_lo_k", m_lo, 32'h80000000);
    md_op("divu_z", F_DIVU, 5, 0);
    md_op("div_z", F_DIV, 32'hFFFFFFF0, 0);

    // MTLO/MFLO in idle, zero latency
    mt_op(F_MTLO, 32'h1234);
    mf_chk("mflo", F_MFLO, 32'h1234);
    mt_op(F_MTHI, 32'hABCD0001);
    mf_chk("mfhi", F_MFHI, 32'hABCD0001);

    // ignored encodings
    @(posedge clk); #1;
    present(F_MULT, 3, 3);
    opcode = 6'h08;
    @(posedge clk); #1;
    chk("bad_opc_busy", busy, 0);
    present(6'h20, 3, 3);
    @(negedge clk);
    chk("bad_fn_rv", result_valid, 0);
    chk("bad_fn_res", result, 0);
    @(posedge clk); #1;
    valid = 0;
    chk("bad_fn_busy", busy, 0);

    // MULT then MFHI held until the result lands
    model(F_MULT, 5, 32'hFFFFFFFD, e.hi, e.lo, n);
    e.tag = "mult_st";
    e.dz = 0;
    e.cyc = 33;
    @(posedge clk); #1;
    present(F_MULT, 5, 32'hFFFFFFFD);
    sb.push_back(e);
    @(posedge clk); #1;
    funct = F_MFHI;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!stall) break;
      n++;
    end
    chk("st_cycles", n, 33);
    chk("st_rv", result_valid, 1);
    chk("st_res", result, 32'hFFFFFFFF);
    @(posedge clk); #1;
    valid = 0;
    m_hi = e.hi;
    m_lo = e.lo;

    // flush on iteration 10 of DIVU 100/7
    e.tag = "flush";
    e.hi = m_hi;
    e.lo = m_lo;
    e.dz = 0;
    e.cyc = 10;
    @(posedge clk); #1;
    present(F_DIVU, 100, 7);
    sb.push_back(e);
    @(posedge clk); #1;
    valid = 0;
    repeat (9) @(posedge clk);
    #1 flush = 1;
    @(posedge clk); #1;
    flush = 0;
    chk("flush_busy", busy, 0);
    @(posedge clk);

    // ops presented with flush are not accepted
    @(posedge clk); #1;
    present(F_MULT, 9, 9);
    flush = 1;
    @(posedge clk); #1;
    present(F_MTHI, 32'hDEAD, 0);
    @(posedge clk); #1;
    valid = 0;
    flush = 0;
    chk("flush_mult_busy", busy, 0);
    chk("flush_mthi_hi", hi, m_hi);

    // random ops against the model
    for (int i = 0; i < 8; i++) begin
      fr = 6'h18 + 6'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 5) ? 32'h0 : $urandom >> $urandom_range(0, 28);
      md_op("rnd", fr, ra, rb);
    end

    // async reset during MUL
    e.tag = "rst_mid";
    e.hi = 0;
    e.lo = 0;
    e.dz = 0;
    e.cyc = -1;
    @(posedge clk); #1;
    present(F_MULT, 32'h12345, 32'h777);
    sb.push_back(e);
    @(posedge clk); #1;
    valid = 0;
    repeat (5) @(posedge clk);
    #2 present(F_MFHI, 0, 0);
    #1 chk("rst_pre_stall", stall, 1);
    rst_n = 0;
    #1;
    chk("rstm_hi", hi, 0);
    chk("rstm_lo", lo, 0);
    chk("rstm_busy", busy, 0);
    chk("rstm_stall", stall, 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("rst_mfhi_stall", stall, 0);
    chk("rst_mfhi_rv", result_valid, 1);
    chk("rst_mfhi_res", result, 0);
    @(posedge clk); #1;
    valid = 0;
    repeat (2) @(posedge clk);

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
